shift_rx_sequencer: RTL

//  Sequences a serial-in, right-shifting capture register: frames WIDTH

---
 rtl/shift_rx_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/shift_rx_sequencer.sv
// -----------------------------------------------------------------------------
// shift_rx_sequencer
//
// Frames WIDTH strobed serial bits per start command into a right-shifting
// capture register. The first bit received ends up in out_data[0]. Each
// completed word is passed to a downstream consumer through a one-entry
// valid/ready buffer. If the buffer is still full when a word completes, that
// word is dropped and a sticky overrun flag is raised.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a frame (only honoured while idle)
//   abort      synchronous abort: drop the partial word and go idle
//   sin        serial data bit
//   sin_en     bit strobe, sin is valid this cycle
//   out_data   completed word (held in the output buffer)
//   out_valid  out_data holds a word not yet consumed
//   out_ready  consumer accepts the word when out_valid && out_ready
//   busy       high while a frame is being shifted in
//   bit_cnt    number of bits captured in the current frame
//   overrun    sticky: a completed word was dropped because the buffer was full
//   clr_ovr    synchronous clear of overrun
// -----------------------------------------------------------------------------
module shift_rx_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             sin,
    input  logic             sin_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             overrun,
    input  logic             clr_ovr
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0] out_data_nxt;
    logic             valid_nxt;
    logic             ovr_nxt;
    logic [WIDTH-1:0] word;
    logic             complete;
    logic             consume;

    // The word as it would look with this cycle's bit shifted in at the top.
    assign word    = {sin, sreg[WIDTH-1:1]};
    assign consume = out_valid && out_ready;

    // ---- Sequencer: next state, counter and shift register -----------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        sreg_nxt  = sreg;
        complete  = 1'b0;
        if (abort) begin
            // Abort outranks both start and last-bit completion.
            state_nxt = IDLE;
            cnt_nxt   = '0;
            sreg_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    // A strobe arriving with start is not part of the frame.
                    if (start) begin
                        state_nxt = SHIFT;
                        cnt_nxt   = '0;
                    end
                end
                SHIFT: begin
                    if (sin_en) begin
                        sreg_nxt = word;
                        if (bit_cnt == LAST_CNT) begin
                            complete  = 1'b1;
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = bit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // ---- Output buffer and overrun flag -------------------------------------
    always_comb begin
        out_data_nxt = out_data;
        valid_nxt    = out_valid;
        ovr_nxt      = overrun;
        if (clr_ovr) begin
            ovr_nxt = 1'b0;
        end
        if (complete) begin
            if (!out_valid || out_ready) begin
                // Consume and reload in the same cycle keeps out_valid high.
                out_data_nxt = word;
                valid_nxt    = 1'b1;
            end else begin
                // Setting the flag takes precedence over a same-cycle clear.
                ovr_nxt = 1'b1;
            end
        end else if (consume) begin
            valid_nxt = 1'b0;
        end
    end

    // ---- Registers -----------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sreg      <= '0;
            bit_cnt   <= '0;
            busy      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            sreg      <= sreg_nxt;
            bit_cnt   <= cnt_nxt;
            busy      <= (state_nxt == SHIFT);
            out_data  <= out_data_nxt;
            out_valid <= valid_nxt;
            overrun   <= ovr_nxt;
        end
    end

endmodule
